// File: rtl/ioctl_loader_pkg.sv
// Shared types and constants for the ioctl download loader.
package ioctl_loader_pkg;

  // Loader control states.
  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } loader_state_t;

  // ioctl_index used by the HPS for the ROM BIOS image.
  localparam logic [7:0] IOCTL_IDX_ROMBIOS = 8'h00;

  // Exchange the two bytes of a 16-bit word.
  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/ioctl_fifo.sv
// Small synchronous FIFO with occupancy count; depth must be a power of two.
module ioctl_fifo #(
  parameter int unsigned Width = 41,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  // Pointer and occupancy update; pushes to a full FIFO are discarded.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q + PtrW'(push_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(pop_ok);
    count_d  = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  // Control state register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care once the pointers are reset.
  always_ff @(posedge clk_sys) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);

endmodule

// File: rtl/ioctl_loader.sv
// Receives the HPS ioctl download stream, buffers words and writes them to SDRAM.
module ioctl_loader
  import ioctl_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 25,
  parameter logic [7:0]        LOAD_INDEX = IOCTL_IDX_ROMBIOS,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [15:0]       ioctl_dout,
  output logic              ioctl_wait,
  input  logic              swap,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              loading,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count
);

  localparam int unsigned EntryW = ADDR_W + 16;
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;

  loader_state_t     state_q, state_d;
  logic              swap_q, swap_d;
  logic              overflow_q, overflow_d;
  logic              wait_q, wait_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0] fifo_din, fifo_dout;
  logic [CntW-1:0]   fifo_count, count_next;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  // Only the word address matters; the byte lane bit is dropped.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ioctl_addr[0];

  ioctl_fifo #(
    .Width (EntryW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (fifo_din),
    .dout    (fifo_dout),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Incoming word formatting, FIFO strobes and post-cycle occupancy.
  always_comb begin
    wr_data    = swap_q ? byte_swap(ioctl_dout) : ioctl_dout;
    wr_addr    = BASE_ADDR + {ioctl_addr[ADDR_W-1:1], 1'b0};
    fifo_din   = {wr_addr, wr_data};
    fifo_push  = (state_q == LOAD) && ioctl_wr && !fifo_full;
    // An ack with no request outstanding is ignored.
    fifo_pop   = mem_req_q && mem_ack;
    count_next = fifo_count + CntW'(fifo_push) - CntW'(fifo_pop);
    // Raised one word early so a write already in flight still fits.
    wait_d     = (count_next >= CntW'(FIFO_DEPTH - 1));
  end

  // Memory request handshake: load head entry, hold until ack, then idle a cycle.
  always_comb begin
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (mem_req_q) begin
      if (mem_ack) begin
        mem_req_d = 1'b0;
      end
    end else if (!fifo_empty) begin
      mem_req_d                 = 1'b1;
      {mem_addr_d, mem_wdata_d} = fifo_dout;
    end
  end

  // Loader FSM next state plus per-load bookkeeping (swap, overflow, word count).
  always_comb begin
    state_d      = state_q;
    swap_d       = swap_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
    if (fifo_pop) begin
      word_count_d = word_count_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (ioctl_download && (ioctl_index == LOAD_INDEX)) begin
          state_d      = LOAD;
          swap_d       = swap;
          overflow_d   = 1'b0;
          word_count_d = '0;
        end
      end
      LOAD: begin
        if (ioctl_wr && fifo_full) begin
          overflow_d = 1'b1;
        end
        if (!ioctl_download) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Leave as soon as the last ack retires so done follows it directly.
        if ((count_next == '0) && !mem_req_d) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      swap_q       <= 1'b0;
      overflow_q   <= 1'b0;
      wait_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      swap_q       <= swap_d;
      overflow_q   <= overflow_d;
      wait_q       <= wait_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      word_count_q <= word_count_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign loading    = (state_q == LOAD) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_ioctl_loader.sv
// Directed bench for ioctl_loader: two instances differing only in BASE_ADDR.
module tb_ioctl_loader;

  localparam int AW = 25;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_download, ioctl_wr, swap, mem_ack;
  logic [7:0]    ioctl_index;
  logic [AW-1:0] ioctl_addr;
  logic [15:0]   ioctl_dout;

  logic          ioctl_wait, mem_req, loading, done, overflow;
  logic [AW-1:0] mem_addr, word_count;
  logic [15:0]   mem_wdata;

  logic          ioctl_wait_b, mem_req_b, loading_b, done_b, overflow_b;
  logic [AW-1:0] mem_addr_b, word_count_b;
  logic [15:0]   mem_wdata_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int done_cnt = 0, req_cnt = 0, load_cnt = 0, wait_cnt = 0;

  // Memory responder state, written only by the responder process.
  bit            ack_en  = 1'b0;
  int            ack_lat = 1;
  int            n_wr    = 0;
  int            last_ack_cyc = 0;
  logic [AW-1:0] log_addr [64];
  logic [15:0]   log_data [64];

  always #5 clk_sys = ~clk_sys;

  ioctl_loader #(
    .ADDR_W     (AW),
    .LOAD_INDEX (8'h00),
    .BASE_ADDR  (25'h0),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .swap           (swap),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ack        (mem_ack),
    .loading        (loading),
    .done           (done),
    .overflow       (overflow),
    .word_count     (word_count)
  );

  ioctl_loader #(
    .ADDR_W     (AW),
    .LOAD_INDEX (8'h00),
    .BASE_ADDR  (25'h80_0000),
    .FIFO_DEPTH (4)
  ) dut_b (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait_b),
    .swap           (swap),
    .mem_req        (mem_req_b),
    .mem_addr       (mem_addr_b),
    .mem_wdata      (mem_wdata_b),
    .mem_ack        (mem_ack),
    .loading        (loading_b),
    .done           (done_b),
    .overflow       (overflow_b),
    .word_count     (word_count_b)
  );

  // Cycle counter and activity monitors.
  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (done)       done_cnt <= done_cnt + 1;
    if (mem_req)    req_cnt  <= req_cnt + 1;
    if (loading)    load_cnt <= load_cnt + 1;
    if (ioctl_wait) wait_cnt <= wait_cnt + 1;
  end

  // SDRAM model: acks a request after ack_lat cycles and logs the write.
  initial begin
    int age;
    age = 0;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (mem_ack) begin
        mem_ack = 1'b0;
        age = 0;
      end else if (mem_req) begin
        if (ack_en) begin
          age++;
          if (age >= ack_lat) begin
            if (n_wr < 64) begin
              log_addr[n_wr] = mem_addr;
              log_data[n_wr] = mem_wdata;
            end
            n_wr++;
            last_ack_cyc = cyc;
            mem_ack = 1'b1;
          end
        end
      end else begin
        age = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic sw);
    ioctl_index    = idx;
    swap           = sw;
    ioctl_download = 1'b1;
    tick();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input bit honour);
    int n;
    n = 0;
    if (honour) begin
      while (ioctl_wait && n < 200) begin
        tick();
        n++;
      end
      if (n >= 200) begin
        total++;
        bad++;
        $error("FAIL wait_timeout: observed=stuck expected=released");
      end
    end
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic end_dl_wait_done();
    int n;
    n = 0;
    ioctl_download = 1'b0;
    while (!done && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $error("FAIL done_timeout: observed=no_done expected=done");
    end
  endtask

  initial begin
    int base, d0, r0, l0, w0, gap, n;

    reset_n        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_index    = 8'h00;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    swap           = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_wait",  64'(ioctl_wait), 64'd0);
    chk("rst_req",   64'(mem_req),    64'd0);
    chk("rst_addr",  64'(mem_addr),   64'd0);
    chk("rst_wdata", 64'(mem_wdata),  64'd0);
    chk("rst_load",  64'(loading),    64'd0);
    chk("rst_done",  64'(done),       64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    chk("rst_wc",    64'(word_count), 64'd0);
    reset_n = 1'b1;
    tick();

    // 1: basic swapped load, ack one cycle after each request.
    ack_en = 1'b1;
    ack_lat = 1;
    base = n_wr;
    d0 = done_cnt;
    start_dl(8'h00, 1'b1);
    chk("t1_loading", 64'(loading), 64'd1);
    wr(25'd0, 16'h1234, 1'b1);
    wr(25'd2, 16'h5678, 1'b1);
    wr(25'd4, 16'h9ABC, 1'b1);
    wr(25'd6, 16'hDEF0, 1'b1);
    end_dl_wait_done();
    chk("t1_load_fall", 64'(loading), 64'd0);
    chk("t1_nwr", 64'(n_wr - base), 64'd4);
    chk("t1_a0", 64'(log_addr[base+0]), 64'h0);
    chk("t1_d0", 64'(log_data[base+0]), 64'h3412);
    chk("t1_a1", 64'(log_addr[base+1]), 64'h2);
    chk("t1_d1", 64'(log_data[base+1]), 64'h7856);
    chk("t1_a2", 64'(log_addr[base+2]), 64'h4);
    chk("t1_d2", 64'(log_data[base+2]), 64'hBC9A);
    chk("t1_a3", 64'(log_addr[base+3]), 64'h6);
    chk("t1_d3", 64'(log_data[base+3]), 64'hF0DE);
    chk("t1_wc", 64'(word_count), 64'd4);
    tick();
    chk("t1_done_low", 64'(done), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 2: backpressure with ack held low, host honours wait.
    ack_en = 1'b0;
    base = n_wr;
    start_dl(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) wr(25'(2 * i), 16'hA000 + 16'(i), 1'b1);
    chk("t2_wait_3rd", 64'(ioctl_wait), 64'd1);
    tick();
    tick();
    tick();
    chk("t2_wait_hold", 64'(ioctl_wait), 64'd1);
    chk("t2_req_hold",  64'(mem_req),    64'd1);
    chk("t2_wc_hold",   64'(word_count), 64'd0);
    ack_en = 1'b1;
    for (int i = 3; i < 16; i++) wr(25'(2 * i), 16'hA000 + 16'(i), 1'b1);
    end_dl_wait_done();
    chk("t2_nwr", 64'(n_wr - base), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_a%0d", i), 64'(log_addr[base+i]), 64'(2 * i));
      chk($sformatf("t2_d%0d", i), 64'(log_data[base+i]), 64'(16'hA000 + 16'(i)));
    end
    chk("t2_ovf", 64'(overflow), 64'd0);
    chk("t2_wc",  64'(word_count), 64'd16);
    tick();

    // 3: overflow, host ignores wait and sends five words.
    ack_en = 1'b0;
    base = n_wr;
    start_dl(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) wr(25'(2 * i), 16'hC000 + 16'(i), 1'b0);
    chk("t3_ovf_set", 64'(overflow), 64'd1);
    ack_en = 1'b1;
    end_dl_wait_done();
    chk("t3_nwr", 64'(n_wr - base), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_a%0d", i), 64'(log_addr[base+i]), 64'(2 * i));
      chk($sformatf("t3_d%0d", i), 64'(log_data[base+i]), 64'(16'hC000 + 16'(i)));
    end
    chk("t3_wc",       64'(word_count), 64'd4);
    chk("t3_ovf_stky", 64'(overflow),   64'd1);
    tick();

    // 4: foreign index is ignored.
    d0 = done_cnt;
    r0 = req_cnt;
    l0 = load_cnt;
    w0 = wait_cnt;
    base = n_wr;
    start_dl(8'h01, 1'b0);
    for (int i = 0; i < 8; i++) wr(25'(2 * i), 16'h7700 + 16'(i), 1'b0);
    ioctl_download = 1'b0;
    tick();
    tick();
    tick();
    chk("t4_req",  64'(req_cnt - r0),  64'd0);
    chk("t4_load", 64'(load_cnt - l0), 64'd0);
    chk("t4_wait", 64'(wait_cnt - w0), 64'd0);
    chk("t4_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_nwr",  64'(n_wr - base),   64'd0);
    chk("t4_wc",   64'(word_count),    64'd4);

    // 5: drain with 3 buffered words and 4-cycle ack latency.
    ack_en = 1'b1;
    ack_lat = 4;
    base = n_wr;
    start_dl(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) wr(25'(2 * i), 16'hE000 + 16'(i), 1'b0);
    ioctl_download = 1'b0;
    chk("t5_req",     64'(mem_req),     64'd1);
    chk("t5_addr_b",  64'(mem_addr_b),  64'h80_0000);
    chk("t5_wdata_b", 64'(mem_wdata_b), 64'hE000);
    chk("t5_addr_a",  64'(mem_addr),    64'h0);
    gap = 0;
    n = 0;
    while (!done && n < 300) begin
      if (!loading) gap++;
      tick();
      n++;
    end
    chk("t5_done_seen", 64'(done), 64'd1);
    chk("t5_load_gap",  64'(gap),  64'd0);
    chk("t5_load_fall", 64'(loading), 64'd0);
    chk("t5_done_lat",  64'(cyc - last_ack_cyc), 64'd1);
    chk("t5_nwr", 64'(n_wr - base), 64'd3);
    chk("t5_a2",  64'(log_addr[base+2]), 64'h4);
    chk("t5_d2",  64'(log_data[base+2]), 64'hE002);
    chk("t5_wc",  64'(word_count), 64'd3);
    tick();

    // 6: reset while a request is outstanding, then a fresh load.
    ack_en = 1'b0;
    ack_lat = 1;
    start_dl(8'h00, 1'b0);
    wr(25'h10, 16'h5555, 1'b0);
    tick();
    chk("t6_req_pre", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_req",   64'(mem_req),    64'd0);
    chk("t6_addr",  64'(mem_addr),   64'd0);
    chk("t6_wdata", 64'(mem_wdata),  64'd0);
    chk("t6_load",  64'(loading),    64'd0);
    chk("t6_wait",  64'(ioctl_wait), 64'd0);
    chk("t6_wc",    64'(word_count), 64'd0);
    ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    ack_en = 1'b1;
    base = n_wr;
    start_dl(8'h00, 1'b0);
    wr(25'h20, 16'h1111, 1'b1);
    wr(25'h22, 16'h2222, 1'b1);
    end_dl_wait_done();
    chk("t6_nwr", 64'(n_wr - base), 64'd2);
    chk("t6_a0",  64'(log_addr[base+0]), 64'h20);
    chk("t6_d0",  64'(log_data[base+0]), 64'h1111);
    chk("t6_d1",  64'(log_data[base+1]), 64'h2222);
    chk("t6_wc2", 64'(word_count), 64'd2);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ioctl_loader.md
Name: ioctl_loader

Overview:
- Core-side receiver for the HPS ioctl download stream. It accepts 16-bit words on ioctl_wr, applies optional byte swap, and buffers them in a small FIFO.
- Issues word writes to the SDRAM controller through a req/ack handshake and drives ioctl_wait to throttle the host.
- Sits in mycore between the ioctl inputs and the sdram arbiter.
- Also provides the "loading" signal that holds the machine in reset while the ROM BIOS is written.

Parameters:
- ADDR_W, 25: ioctl/memory byte address width.
- LOAD_INDEX, 8'h00: ioctl_index value accepted; any other index is ignored.
- BASE_ADDR, 25'h0: byte offset added to ioctl_addr.
- FIFO_DEPTH, 4: word buffer depth, power of two, minimum 2.

Ports:
- clk_sys  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download window from HPS.
- ioctl_index  in  8  download target index.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  ADDR_W  byte address of the word; bit 0 is ignored.
- ioctl_dout  in  16  word data.
- ioctl_wait  out  1  host must not issue ioctl_wr while high.
- swap  in  1  byte-swap enable, sampled on download start.
- mem_req  out  1  write request, held until ack.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  one-cycle completion pulse.
- loading  out  1  high while a matching download is active or draining.
- done  out  1  one-cycle pulse when the load completes.
- overflow  out  1  sticky; a write arrived while the FIFO was full.
- word_count  out  ADDR_W  words written to memory in the current or last load.

Behaviour:
- Reset (async assert, sync release): state IDLE; FIFO empty; all outputs 0, including mem_addr, mem_wdata and word_count.
- States:
  - IDLE: on ioctl_download=1 with ioctl_index==LOAD_INDEX, go to LOAD. Latch swap, clear overflow and word_count. loading=1 from the next cycle.
  - LOAD: accept writes. ioctl_download=0 goes to DRAIN.
  - DRAIN: when the FIFO is empty and mem_req=0, go to DONE.
  - DONE: done=1 for one cycle, loading=0, then IDLE.
- Non-matching index: the stream is ignored entirely. ioctl_wait stays 0, no mem_req is issued, and loading stays 0. Return to IDLE when the download falls.
- FIFO push on ioctl_wr in LOAD:
  - Entry = {BASE_ADDR + {ioctl_addr[ADDR_W-1:1],1'b0}, data}.
  - data = swap_latched ? {dout[7:0],dout[15:8]} : dout.
- Push while full: the word is dropped and overflow is set.
- ioctl_wait is registered. It is 1 when the FIFO count ≥ FIFO_DEPTH-1 after this cycle's push/pop, so the host has one cycle of slack.
- Memory side:
  - When mem_req=0 and the FIFO is non-empty, assert mem_req next cycle with the head entry on mem_addr/mem_wdata.
  - Hold mem_req and its outputs stable until mem_ack.
  - On mem_ack: pop, increment word_count, and drop mem_req for at least one cycle.
  - Minimum throughput is one word per 3 cycles.
- mem_ack while mem_req=0 is ignored.
- Push and pop in the same cycle: count is unchanged; both complete.
- A new matching download while in DRAIN or DONE is not accepted until IDLE.
- word_count wraps modulo 2^ADDR_W.
- Reset mid-transfer: mem_req drops immediately and FIFO contents are discarded. The SDRAM controller must treat the request as abandoned.

Decomposition:
- core_pkg additions:
  - loader_state_t enum {IDLE, LOAD, DRAIN, DONE}.
  - IOCTL_IDX_ROMBIOS = 8'h00.
- Sub-module ioctl_fifo:
  - Synchronous FIFO parameterised on width and depth.
  - Ports: push, pop, din, dout, count, full, empty.
  - Async active-low reset.

Test Plan:
1. Basic load: index 0, swap=1, words 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0 at addr 0/2/4/6, mem_ack 1 cycle after each req.
   -> Memory writes {0:3412, 2:7856, 4:BC9A, 6:F0DE}; word_count=4; exactly one done pulse; loading falls with done.
2. Backpressure: mem_ack held low, host honours wait.
   -> ioctl_wait=1 after the 3rd write; host stalls. Release ack: all 16 words land in order at addr 0..30; overflow=0.
3. Overflow: mem_ack low, host ignores wait and sends 5 words.
   -> overflow=1; only words 1–4 are written after ack resumes; word_count=4.
4. Foreign index 8'h01 with 8 words.
   -> No mem_req, loading=0, ioctl_wait=0, done never pulses.
5. Drain: download falls with 3 words buffered and 4-cycle ack latency.
   -> loading stays 1 until the last ack; done 1 cycle later; BASE_ADDR=25'h80_0000 gives first mem_addr 25'h80_0000.
6. Reset mid-load: reset_n low while mem_req=1.
   -> mem_req=0 and all outputs 0 in the same cycle. A subsequent fresh download completes normally with word_count counting from 0.
